rs_integer_station: RTL and testbench

- Integer reservation station directly downstream of the dispatch stage.
- Accepts 76-bit integer packets from dispatch and holds them until both operands are valid.
- Captures missing operands from the common data bus (CDB) by ROB tag.
- Issues one ready entry per cycle to the integer ALU through a registered valid/ready interface.
- Drives the full flag that dispatch uses to stall.

---
 rtl/rs_integer_station_if.sv | 27 ++
 rtl/rs_integer_station.sv | 200 ++++++++++++++++++++
 tb/tb_rs_integer_station.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rs_integer_station_if.sv
// rtl/rs_integer_station_if.sv - dispatch, CDB and ALU-issue signal bundle for the integer reservation station
interface rs_integer_station_if #(
    parameter int TAG_W = 6
);
    logic             dispatch_en;
    logic [75:0]      dispatch_data;
    logic             rs_is_full;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_value;
    logic             alu_ready;
    logic             issue_valid;
    logic [3:0]       issue_op;
    logic [TAG_W-1:0] issue_tag;
    logic [31:0]      issue_src1;
    logic [31:0]      issue_src2;

    modport master (
        output dispatch_en, dispatch_data, cdb_valid, cdb_tag, cdb_value, alu_ready,
        input  rs_is_full, issue_valid, issue_op, issue_tag, issue_src1, issue_src2
    );

    modport slave (
        input  dispatch_en, dispatch_data, cdb_valid, cdb_tag, cdb_value, alu_ready,
        output rs_is_full, issue_valid, issue_op, issue_tag, issue_src1, issue_src2
    );
endinterface

// File: rtl/rs_integer_station.sv
// rtl/rs_integer_station.sv - integer reservation station with CDB wakeup and registered ALU issue
// Optional macro RS_OLDEST_FIRST_EN: age-matrix oldest-ready select instead of lowest index.
module rs_integer_station #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    rs_integer_station_if.slave bus
);
    localparam int IW = $clog2(DEPTH);

    logic [DEPTH-1:0] busy_q, busy_d, v1_q, v1_d, v2_q, v2_d;
    logic [3:0]       op_q   [DEPTH];
    logic [3:0]       op_d   [DEPTH];
    logic [TAG_W-1:0] dtag_q [DEPTH];
    logic [TAG_W-1:0] dtag_d [DEPTH];
    logic [31:0]      src1_q [DEPTH];
    logic [31:0]      src1_d [DEPTH];
    logic [31:0]      src2_q [DEPTH];
    logic [31:0]      src2_d [DEPTH];

    logic             iv_q, iv_d;
    logic [3:0]       iop_q, iop_d;
    logic [TAG_W-1:0] itag_q, itag_d;
    logic [31:0]      is1_q, is1_d, is2_q, is2_d;

    logic [DEPTH-1:0] ready, cand;
    logic             full, ins_en, load, sel_any;
    logic [IW-1:0]    ins_idx, sel_idx;

    logic [3:0]       pk_op;
    logic [TAG_W-1:0] pk_tag;
    logic             pk_v1, pk_v2, byp1, byp2;
    logic [31:0]      pk_s1, pk_s2;

    assign pk_op  = bus.dispatch_data[75:72];
    assign pk_tag = TAG_W'(bus.dispatch_data[71:66]);
    assign pk_v1  = bus.dispatch_data[65];
    assign pk_s1  = bus.dispatch_data[64:33];
    assign pk_v2  = bus.dispatch_data[32];
    assign pk_s2  = bus.dispatch_data[31:0];
    // A pending operand's producer tag lives in the low bits of its operand field.
    assign byp1 = !pk_v1 && bus.cdb_valid && (bus.cdb_tag == TAG_W'(pk_s1[5:0]));
    assign byp2 = !pk_v2 && bus.cdb_valid && (bus.cdb_tag == TAG_W'(pk_s2[5:0]));

    assign ready   = busy_q & v1_q & v2_q;
    assign full    = &busy_q;
    assign ins_en  = bus.dispatch_en && !full;
    assign load    = !iv_q || bus.alu_ready;
    assign sel_any = |cand;

`ifdef RS_OLDEST_FIRST_EN
    // age_q[r][c] set means entry r was inserted before entry c.
    logic [DEPTH-1:0] age_q [DEPTH];
    logic [DEPTH-1:0] age_d [DEPTH];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            cand[i] = ready[i];
            for (int j = 0; j < DEPTH; j++) begin
                if (ready[j] && age_q[j][i]) cand[i] = 1'b0;
            end
        end
    end

    always_comb begin
        age_d = age_q;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) age_d[i] = '0;
        end else begin
            if (load && sel_any) begin
                for (int j = 0; j < DEPTH; j++) begin
                    age_d[sel_idx][j] = 1'b0;
                    age_d[j][sel_idx] = 1'b0;
                end
            end
            if (ins_en) begin
                for (int j = 0; j < DEPTH; j++) begin
                    age_d[ins_idx][j] = 1'b0;
                    age_d[j][ins_idx] = (IW'(j) != ins_idx);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
        end else begin
            age_q <= age_d;
        end
    end
`else
    assign cand = ready;
`endif

    always_comb begin
        ins_idx = '0;
        sel_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!busy_q[i]) ins_idx = IW'(i);
            if (cand[i])    sel_idx = IW'(i);
        end
    end

    always_comb begin
        busy_d = busy_q;
        v1_d   = v1_q;
        v2_d   = v2_q;
        op_d   = op_q;
        dtag_d = dtag_q;
        src1_d = src1_q;
        src2_d = src2_q;
        iv_d   = iv_q;
        iop_d  = iop_q;
        itag_d = itag_q;
        is1_d  = is1_q;
        is2_d  = is2_q;

        if (bus.cdb_valid) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (busy_q[i] && !v1_q[i] && (TAG_W'(src1_q[i][5:0]) == bus.cdb_tag)) begin
                    v1_d[i]   = 1'b1;
                    src1_d[i] = bus.cdb_value;
                end
                if (busy_q[i] && !v2_q[i] && (TAG_W'(src2_q[i][5:0]) == bus.cdb_tag)) begin
                    v2_d[i]   = 1'b1;
                    src2_d[i] = bus.cdb_value;
                end
            end
        end

        if (load) begin
            iv_d = sel_any;
            if (sel_any) begin
                iop_d           = op_q[sel_idx];
                itag_d          = dtag_q[sel_idx];
                is1_d           = src1_q[sel_idx];
                is2_d           = src2_q[sel_idx];
                busy_d[sel_idx] = 1'b0;
            end
        end

        if (ins_en) begin
            busy_d[ins_idx] = 1'b1;
            op_d[ins_idx]   = pk_op;
            dtag_d[ins_idx] = pk_tag;
            v1_d[ins_idx]   = pk_v1 || byp1;
            v2_d[ins_idx]   = pk_v2 || byp2;
            src1_d[ins_idx] = byp1 ? bus.cdb_value : pk_s1;
            src2_d[ins_idx] = byp2 ? bus.cdb_value : pk_s2;
        end

        if (flush) begin
            busy_d = '0;
            iv_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
            v1_q   <= '0;
            v2_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op_q[i]   <= '0;
                dtag_q[i] <= '0;
                src1_q[i] <= '0;
                src2_q[i] <= '0;
            end
            iv_q   <= 1'b0;
            iop_q  <= '0;
            itag_q <= '0;
            is1_q  <= '0;
            is2_q  <= '0;
        end else begin
            busy_q <= busy_d;
            v1_q   <= v1_d;
            v2_q   <= v2_d;
            op_q   <= op_d;
            dtag_q <= dtag_d;
            src1_q <= src1_d;
            src2_q <= src2_d;
            iv_q   <= iv_d;
            iop_q  <= iop_d;
            itag_q <= itag_d;
            is1_q  <= is1_d;
            is2_q  <= is2_d;
        end
    end

    assign bus.rs_is_full  = full;
    assign bus.issue_valid = iv_q;
    assign bus.issue_op    = iop_q;
    assign bus.issue_tag   = itag_q;
    assign bus.issue_src1  = is1_q;
    assign bus.issue_src2  = is2_q;
endmodule

// File: tb/tb_rs_integer_station.sv
// tb/tb_rs_integer_station.sv - directed and randomized bench for rs_integer_station against an entry-list model
module tb_rs_integer_station;
    localparam int DEPTH = 4;
    localparam int TAG_W = 6;

    logic clk = 1'b0;
    logic reset;
    logic flush;
    always #5 clk = ~clk;

    rs_integer_station_if #(.TAG_W(TAG_W)) bus ();

    rs_integer_station #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    typedef struct {
        bit          busy;
        bit [3:0]    op;
        bit [5:0]    tag;
        bit          v1;
        bit [31:0]   s1;
        bit          v2;
        bit [31:0]   s2;
        int unsigned seq;
    } ent_t;

    ent_t        m [DEPTH];
    bit          m_iv;
    bit [3:0]    m_iop;
    bit [5:0]    m_itag;
    bit [31:0]   m_is1, m_is2;
    int unsigned seq_ctr;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_full();
        bit f = 1'b1;
        for (int i = 0; i < DEPTH; i++) if (!m[i].busy) f = 1'b0;
        return f;
    endfunction

    function automatic logic [75:0] pkt(input logic [3:0] op, input logic [5:0] tg,
                                        input logic v1, input logic [31:0] o1,
                                        input logic v2, input logic [31:0] o2);
        return {op, tg, v1, o1, v2, o2};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m[i] = '{default: 0};
        m_iv = 0; m_iop = 0; m_itag = 0; m_is1 = 0; m_is2 = 0;
        seq_ctr = 0;
    endtask

    // Next state from the rules: wake by tag, issue the preferred ready entry, insert into lowest free slot.
    task automatic model_step();
        ent_t        n [DEPTH];
        int          pick, slot;
        bit          full;
        logic [75:0] d;
        full = m_full();
        n = m;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) n[i].busy = 0;
            m = n;
            m_iv = 0;
            return;
        end
        pick = -1;
        for (int i = 0; i < DEPTH; i++) begin
            if (m[i].busy && m[i].v1 && m[i].v2) begin
`ifdef RS_OLDEST_FIRST_EN
                if (pick < 0 || m[i].seq < m[pick].seq) pick = i;
`else
                if (pick < 0) pick = i;
`endif
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (m[i].busy && bus.cdb_valid) begin
                if (!m[i].v1 && m[i].s1[5:0] == bus.cdb_tag) begin n[i].v1 = 1; n[i].s1 = bus.cdb_value; end
                if (!m[i].v2 && m[i].s2[5:0] == bus.cdb_tag) begin n[i].v2 = 1; n[i].s2 = bus.cdb_value; end
            end
        end
        if (!m_iv || bus.alu_ready) begin
            if (pick >= 0) begin
                m_iv = 1; m_iop = m[pick].op; m_itag = m[pick].tag;
                m_is1 = m[pick].s1; m_is2 = m[pick].s2;
                n[pick].busy = 0;
            end else begin
                m_iv = 0;
            end
        end
        if (bus.dispatch_en && full)
            $display("note: dispatch with rs_is_full=1, packet dropped (protocol error)");
        if (bus.dispatch_en && !full) begin
            slot = -1;
            for (int i = 0; i < DEPTH; i++) if (!m[i].busy && slot < 0) slot = i;
            d = bus.dispatch_data;
            n[slot].busy = 1;
            n[slot].op   = d[75:72];
            n[slot].tag  = d[71:66];
            n[slot].v1   = d[65];
            n[slot].s1   = d[64:33];
            n[slot].v2   = d[32];
            n[slot].s2   = d[31:0];
            if (!d[65] && bus.cdb_valid && d[38:33] == bus.cdb_tag) begin n[slot].v1 = 1; n[slot].s1 = bus.cdb_value; end
            if (!d[32] && bus.cdb_valid && d[5:0] == bus.cdb_tag)   begin n[slot].v2 = 1; n[slot].s2 = bus.cdb_value; end
            n[slot].seq = seq_ctr;
            seq_ctr++;
        end
        m = n;
    endtask

    task automatic check_model(input string ctx);
        chk({ctx, ".full"}, 32'(bus.rs_is_full), 32'(m_full()));
        chk({ctx, ".valid"}, 32'(bus.issue_valid), 32'(m_iv));
        if (m_iv) begin
            chk({ctx, ".op"},   32'(bus.issue_op),  32'(m_iop));
            chk({ctx, ".tag"},  32'(bus.issue_tag), 32'(m_itag));
            chk({ctx, ".src1"}, bus.issue_src1, m_is1);
            chk({ctx, ".src2"}, bus.issue_src2, m_is2);
        end
    endtask

    task automatic step(input string ctx);
        model_step();
        @(posedge clk);
        #1;
        check_model(ctx);
    endtask

    task automatic idle();
        flush = 0;
        bus.dispatch_en = 0;
        bus.dispatch_data = '0;
        bus.cdb_valid = 0;
        bus.cdb_tag = '0;
        bus.cdb_value = '0;
    endtask

    task automatic cdb(input logic [5:0] tg, input logic [31:0] val);
        bus.cdb_valid = 1; bus.cdb_tag = tg; bus.cdb_value = val;
    endtask

    task automatic disp(input logic [75:0] p);
        bus.dispatch_en = 1; bus.dispatch_data = p;
    endtask

    initial begin
        logic [31:0] r1, r2;
        logic        v1, v2;
        reset = 1;
        idle();
        bus.alu_ready = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        chk("rst.valid", 32'(bus.issue_valid), 0);
        chk("rst.full",  32'(bus.rs_is_full), 0);
        chk("rst.op",    32'(bus.issue_op), 0);
        chk("rst.tag",   32'(bus.issue_tag), 0);
        chk("rst.src1",  bus.issue_src1, 0);
        chk("rst.src2",  bus.issue_src2, 0);

        // Both operands valid: issue one edge after insert.
        bus.alu_ready = 1;
        disp(pkt(4'h0, 6'd3, 1, 32'd5, 1, 32'd7));
        step("t1.ins");
        idle();
        step("t1.e1");
        chk("t1.valid", 32'(bus.issue_valid), 1);
        chk("t1.tag",   32'(bus.issue_tag), 3);
        chk("t1.src1",  bus.issue_src1, 5);
        chk("t1.src2",  bus.issue_src2, 7);
        step("t1.e2");
        chk("t1.drain", 32'(bus.issue_valid), 0);

        // Wakeup on src1 two cycles after insert.
        disp(pkt(4'h1, 6'd4, 0, 32'd9, 1, 32'd2));
        step("t2.ins");
        idle();
        step("t2.gap");
        cdb(6'd9, 32'h1234);
        step("t2.cdb");
        chk("t2.notyet", 32'(bus.issue_valid), 0);
        idle();
        step("t2.iss");
        chk("t2.valid", 32'(bus.issue_valid), 1);
        chk("t2.src1",  bus.issue_src1, 32'h1234);
        step("t2.drain");

        // Insert-time bypass on src2.
        disp(pkt(4'h2, 6'd12, 1, 32'd3, 0, 32'd12));
        cdb(6'd12, 32'hFF);
        step("t3.ins");
        idle();
        step("t3.iss");
        chk("t3.valid", 32'(bus.issue_valid), 1);
        chk("t3.src2",  bus.issue_src2, 32'hFF);
        step("t3.drain");

        // Fill, drop a fifth dispatch, wake all, hold, release.
        bus.alu_ready = 0;
        for (int i = 0; i < DEPTH; i++) begin
            disp(pkt(4'h5, 6'(20 + i), 0, 32'(30 + i), 1, 32'(i)));
            step("t4.fill");
        end
        chk("t4.full", 32'(bus.rs_is_full), 1);
        disp(pkt(4'h6, 6'd40, 1, 32'd1, 1, 32'd1));
        step("t4.drop");
        chk("t4.fullheld", 32'(bus.rs_is_full), 1);
        idle();
        for (int i = 0; i < DEPTH; i++) begin
            cdb(6'(30 + i), 32'hA000_0000 + 32'(i));
            step("t4.wake");
        end
        idle();
        for (int k = 0; k < 3; k++) begin
            step("t4.hold");
            chk("t4.hold.valid", 32'(bus.issue_valid), 1);
            chk("t4.hold.tag",   32'(bus.issue_tag), 20);
            chk("t4.hold.src1",  bus.issue_src1, 32'hA000_0000);
        end
        bus.alu_ready = 1;
        for (int i = 1; i < DEPTH; i++) begin
            step("t4.rel");
            chk("t4.rel.tag", 32'(bus.issue_tag), 32'(20 + i));
        end
        step("t4.end");
        chk("t4.empty", 32'(bus.issue_valid), 0);

        // Slot 2 older than slot 0, both woken by one broadcast.
        disp(pkt(4'h3, 6'd50, 0, 32'd20, 1, 32'd0)); step("t5.x");
        disp(pkt(4'h3, 6'd51, 0, 32'd21, 1, 32'd0)); step("t5.y");
        disp(pkt(4'h3, 6'd52, 0, 32'd22, 1, 32'd0)); step("t5.z");
        idle(); cdb(6'd20, 32'd100);                step("t5.wx");
        idle();                                      step("t5.ix");
        disp(pkt(4'h3, 6'd53, 0, 32'd22, 1, 32'd0)); step("t5.w");
        idle(); cdb(6'd22, 32'd222);                step("t5.wzw");
        idle();                                      step("t5.sel");
`ifdef RS_OLDEST_FIRST_EN
        chk("t5.first", 32'(bus.issue_tag), 52);
`else
        chk("t5.first", 32'(bus.issue_tag), 53);
`endif
        step("t5.second");
        cdb(6'd21, 32'd321);                         step("t5.wy");
        idle();
        repeat (3) step("t5.drain");

        // Flush with three busy entries, a held issue, and a concurrent dispatch.
        bus.alu_ready = 0;
        disp(pkt(4'h7, 6'd5, 1, 32'd1, 1, 32'd2)); step("t6.r");
        for (int i = 0; i < 3; i++) begin
            disp(pkt(4'h8, 6'(60 + i), 0, 32'(40 + i), 1, 32'd0));
            step("t6.fill");
        end
        chk("t6.pre.valid", 32'(bus.issue_valid), 1);
        disp(pkt(4'h9, 6'd7, 1, 32'd9, 1, 32'd9));
        flush = 1;
        step("t6.flush");
        chk("t6.full",  32'(bus.rs_is_full), 0);
        chk("t6.valid", 32'(bus.issue_valid), 0);
        idle();
        bus.alu_ready = 1;
        step("t6.after");
        chk("t6.nostore", 32'(bus.issue_valid), 0);

        // Asynchronous reset mid-operation.
        bus.alu_ready = 0;
        disp(pkt(4'hA, 6'd33, 1, 32'd4, 1, 32'd4)); step("t7.a");
        disp(pkt(4'hA, 6'd34, 0, 32'd50, 1, 32'd4)); step("t7.b");
        idle();
        #3 reset = 1;
        #1;
        chk("t7.valid", 32'(bus.issue_valid), 0);
        chk("t7.tag",   32'(bus.issue_tag), 0);
        chk("t7.full",  32'(bus.rs_is_full), 0);
        model_reset();
        #1 reset = 0;

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            flush = ($urandom_range(0, 99) < 3);
            v1 = $urandom_range(0, 1);
            v2 = $urandom_range(0, 1);
            r1 = $urandom;
            r2 = $urandom;
            if (!v1) r1[5:0] = 6'($urandom_range(0, 7));
            if (!v2) r2[5:0] = 6'($urandom_range(0, 7));
            bus.dispatch_en = ($urandom_range(0, 99) < 60) && !m_full();
            bus.dispatch_data = pkt(4'($urandom), 6'($urandom), v1, r1, v2, r2);
            bus.cdb_valid = $urandom_range(0, 1);
            bus.cdb_tag = 6'($urandom_range(0, 7));
            bus.cdb_value = $urandom;
            bus.alu_ready = ($urandom_range(0, 99) < 70);
            step("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
